// File: rtl/proc_pkg.sv
// Shared opcodes, FSM state encoding and opcode-legality helper for the multicycle datapath.
package proc_pkg;

    localparam int OP_W = 7;

    localparam logic [OP_W-1:0] OP_NONE  = 7'd0;
    localparam logic [OP_W-1:0] OP_STORE = 7'd1;
    localparam logic [OP_W-1:0] OP_ADD   = 7'd2;
    localparam logic [OP_W-1:0] OP_SUB   = 7'd3;
    localparam logic [OP_W-1:0] OP_LOAD  = 7'd4;
    localparam logic [OP_W-1:0] OP_LI    = 7'd5;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_READ = 3'd1,
        S_EXEC = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4
    } state_t;

    function automatic logic op_legal(input logic [OP_W-1:0] op);
        return op <= OP_LI;
    endfunction

endpackage

// File: rtl/proc_alu.sv
// Combinational ALU: add/sub/pass-immediate, plus base+offset for memory ops.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; its output is sampled by the sequencer when it needs it.
module proc_alu
    import proc_pkg::*;
#(
    parameter int W = 64
) (
    input  logic [W-1:0]    a,
    input  logic [W-1:0]    b,
    input  logic [W-1:0]    imm,
    input  logic [OP_W-1:0] op,
    output logic [W-1:0]    y,
    output logic            zero,
    output logic            ovf
);

    always_comb begin
        y   = '0;
        ovf = 1'b0;
        case (op)
            OP_ADD: begin
                y   = a + b;
                ovf = (a[W-1] == b[W-1]) && (y[W-1] != a[W-1]);
            end
            OP_SUB: begin
                y   = a - b;
                ovf = (a[W-1] != b[W-1]) && (y[W-1] != a[W-1]);
            end
            OP_LI:             y = imm;
            OP_LOAD, OP_STORE: y = a + imm;
            default:           y = '0;
        endcase
    end

    assign zero = (y == '0);

endmodule

// File: rtl/multicycle_datapath.sv
// Multicycle datapath: RF + data memory + ALU sequenced by one FSM, one instruction in flight.
// Latency: accept to done = 3 cycles (LI/ADD/SUB/NONE/STORE), 4 (LOAD), 1 (illegal opcode).
// Backpressure: instr_ready is high only in IDLE; fields are sampled only on the accept edge.
module multicycle_datapath
    import proc_pkg::*;
#(
    parameter int  WORDSIZE = 64,
    parameter int  RF_DEPTH = 32,
    parameter int  DM_DEPTH = 32,
    parameter int  ZERO_REG = 1,
    localparam int RA_W     = $clog2(RF_DEPTH),
    localparam int DA_W     = $clog2(DM_DEPTH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                instr_valid,
    output logic                instr_ready,
    input  logic [OP_W-1:0]     op_code,
    input  logic [RA_W-1:0]     rd,
    input  logic [RA_W-1:0]     rs1,
    input  logic [RA_W-1:0]     rs2,
    input  logic [WORDSIZE-1:0] imm,
    output logic                done,
    output logic                err,
    output logic [WORDSIZE-1:0] result,
    output logic                flag_zero,
    output logic                flag_ovf
);

    state_t state, state_nxt;

    logic [OP_W-1:0]     op_q;
    logic [RA_W-1:0]     rd_q, rs1_q, rs2_q;
    logic [WORDSIZE-1:0] imm_q;
    logic [WORDSIZE-1:0] a_q, b_q, y_q, ld_q;
    logic                zero_q, ovf_q;
    logic [DA_W-1:0]     addr_q;

    logic [WORDSIZE-1:0] rf [RF_DEPTH];
    logic [WORDSIZE-1:0] dm [DM_DEPTH];

    logic [WORDSIZE-1:0] alu_y;
    logic                alu_zero, alu_ovf;
    logic [WORDSIZE-1:0] rd_a, rd_b, wb_val;
    logic                accept, rf_we, dm_we;

    assign instr_ready = (state == S_IDLE);
    assign accept      = instr_valid && instr_ready;

    assign rd_a   = ((ZERO_REG != 0) && (rs1_q == '0)) ? '0 : rf[rs1_q];
    assign rd_b   = ((ZERO_REG != 0) && (rs2_q == '0)) ? '0 : rf[rs2_q];
    assign wb_val = (op_q == OP_LOAD) ? ld_q : y_q;

    // Writes are gated by state, so an async reset mid-instruction can never commit one.
    assign rf_we = (state == S_WB) && (op_q != OP_NONE) &&
                   !((ZERO_REG != 0) && (rd_q == '0));
    assign dm_we = (state == S_MEM) && (op_q == OP_STORE);

    proc_alu #(.W(WORDSIZE)) u_alu (
        .a    (a_q),
        .b    (b_q),
        .imm  (imm_q),
        .op   (op_q),
        .y    (alu_y),
        .zero (alu_zero),
        .ovf  (alu_ovf)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (accept) state_nxt = S_READ;
            S_READ: state_nxt = op_legal(op_q) ? S_EXEC : S_IDLE;
            S_EXEC: state_nxt = ((op_q == OP_LOAD) || (op_q == OP_STORE)) ? S_MEM : S_WB;
            S_MEM:  state_nxt = (op_q == OP_STORE) ? S_IDLE : S_WB;
            S_WB:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Datapath latches carry no reset; they are always refilled before use.
    always_ff @(posedge clk) begin
        if (accept) begin
            op_q  <= op_code;
            rd_q  <= rd;
            rs1_q <= rs1;
            rs2_q <= rs2;
            imm_q <= imm;
        end
        if (state == S_READ) begin
            a_q <= rd_a;
            b_q <= rd_b;
        end
        if (state == S_EXEC) begin
            y_q    <= alu_y;
            zero_q <= alu_zero;
            ovf_q  <= alu_ovf;
            addr_q <= alu_y[DA_W-1:0];
        end
        if (state == S_MEM) ld_q <= dm[addr_q];
    end

    always_ff @(posedge clk) begin
        if (rf_we) rf[rd_q] <= wb_val;
        if (dm_we) dm[addr_q] <= b_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done      <= 1'b0;
            err       <= 1'b0;
            result    <= '0;
            flag_zero <= 1'b0;
            flag_ovf  <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                S_READ: if (!op_legal(op_q)) begin
                    done <= 1'b1;
                    err  <= 1'b1;
                end
                S_MEM: if (op_q == OP_STORE) begin
                    done      <= 1'b1;
                    result    <= b_q;
                    flag_zero <= (b_q == '0);
                    flag_ovf  <= 1'b0;
                end
                S_WB: begin
                    done <= 1'b1;
                    // NONE retires without touching the reported result or flags.
                    if (op_q != OP_NONE) begin
                        result    <= wb_val;
                        flag_zero <= (op_q == OP_LOAD) ? (ld_q == '0) : zero_q;
                        flag_ovf  <= ovf_q;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_datapath.sv
// Randomized bench for multicycle_datapath against an instruction-level reference model.
module tb_multicycle_datapath;
    import proc_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic        instr_ready;
    logic [6:0]  op_code;
    logic [4:0]  rd, rs1, rs2;
    logic [63:0] imm;
    logic        done, err, flag_zero, flag_ovf;
    logic [63:0] result;

    multicycle_datapath dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .op_code     (op_code),
        .rd          (rd),
        .rs1         (rs1),
        .rs2         (rs2),
        .imm         (imm),
        .done        (done),
        .err         (err),
        .result      (result),
        .flag_zero   (flag_zero),
        .flag_ovf    (flag_ovf)
    );

    always #5 clk = ~clk;

    logic [63:0] rf_m [32];
    logic [63:0] dm_m [32];
    logic [63:0] m_res;
    logic        m_zero, m_ovf;
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h, expected 0x%h", tag, got, exp);
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (instr_ready !== 1'b1 && n < 20) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 20) check_eq("ready_timeout", 64'(instr_ready), 64'd1);
    endtask

    // Counts edges from the accept edge until done is seen.
    task automatic wait_done(input string tag, input int exp_lat);
        int lat = 0;
        while (done !== 1'b1 && lat < 12) begin
            @(posedge clk); #1; lat++;
        end
        check_eq({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    endtask

    task automatic scramble_fields();
        op_code = 7'($urandom);
        rd      = 5'($urandom);
        rs1     = 5'($urandom);
        rs2     = 5'($urandom);
        imm     = {$urandom, $urandom};
    endtask

    function automatic logic [63:0] rdreg(input logic [4:0] r);
        return (r == 5'd0) ? 64'd0 : rf_m[r];
    endfunction

    task automatic run_instr(input string tag, input logic [6:0] op, input logic [4:0] d,
                             input logic [4:0] s1, input logic [4:0] s2, input logic [63:0] im);
        logic [63:0]        a, b;
        logic signed [64:0] w;
        int                 exp_lat, addr;
        logic               exp_err, wr;
        a = rdreg(s1);
        b = rdreg(s2);
        exp_lat = 3; exp_err = 1'b0; wr = 1'b0;
        addr = int'((a + im) % 64'd32);
        case (op)
            OP_NONE: ;
            OP_ADD, OP_SUB: begin
                if (op == OP_ADD) w = $signed({a[63], a}) + $signed({b[63], b});
                else              w = $signed({a[63], a}) - $signed({b[63], b});
                m_res = w[63:0];
                m_ovf = (w[64] != w[63]);
                m_zero = (m_res == 64'd0);
                wr = 1'b1;
            end
            OP_LI:    begin m_res = im; m_zero = (im == 64'd0); m_ovf = 1'b0; wr = 1'b1; end
            OP_LOAD:  begin
                m_res = dm_m[addr]; m_zero = (m_res == 64'd0); m_ovf = 1'b0;
                wr = 1'b1; exp_lat = 4;
            end
            OP_STORE: begin dm_m[addr] = b; m_res = b; m_zero = (b == 64'd0); m_ovf = 1'b0; end
            default:  begin exp_err = 1'b1; exp_lat = 1; end
        endcase
        if (wr && d != 5'd0) rf_m[d] = m_res;

        wait_ready();
        op_code = op; rd = d; rs1 = s1; rs2 = s2; imm = im;
        instr_valid = 1'b1;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        scramble_fields();
        wait_done(tag, exp_lat);
        check_eq({tag, "_err"},  64'(err), 64'(exp_err));
        check_eq({tag, "_res"},  result, m_res);
        check_eq({tag, "_zero"}, 64'(flag_zero), 64'(m_zero));
        check_eq({tag, "_ovf"},  64'(flag_ovf), 64'(m_ovf));
    endtask

    task automatic readback(input string tag, input logic [4:0] r);
        run_instr(tag, OP_ADD, 5'd0, r, 5'd0, 64'd0);
    endtask

    initial begin
        rst = 1'b1; instr_valid = 1'b0;
        op_code = '0; rd = '0; rs1 = '0; rs2 = '0; imm = '0;
        m_res = '0; m_zero = 1'b0; m_ovf = 1'b0;
        #12;
        check_eq("rst_ready", 64'(instr_ready), 64'd1);
        check_eq("rst_done",  64'(done), 64'd0);
        check_eq("rst_err",   64'(err), 64'd0);
        check_eq("rst_res",   result, 64'd0);
        check_eq("rst_flags", {62'd0, flag_zero, flag_ovf}, 64'd0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;

        // Bring every register and memory word to a known value.
        for (int i = 1; i < 32; i++) run_instr("init_li", OP_LI, 5'(i), 5'd0, 5'd0, {$urandom, $urandom});
        for (int i = 0; i < 32; i++)
            run_instr("init_st", OP_STORE, 5'($urandom), 5'd0, 5'($urandom), 64'(i));

        run_instr("li_r3", OP_LI, 5'd3, 5'd0, 5'd0, 64'h5);
        run_instr("li_r4", OP_LI, 5'd4, 5'd0, 5'd0, 64'h7);
        run_instr("add_r5", OP_ADD, 5'd5, 5'd3, 5'd4, 64'd0);
        check_eq("add_r5_const", result, 64'hC);
        readback("rb_r5", 5'd5);
        check_eq("rb_r5_const", result, 64'hC);
        run_instr("sub_r6", OP_SUB, 5'd6, 5'd3, 5'd4, 64'd0);
        check_eq("sub_r6_const", result, 64'hFFFF_FFFF_FFFF_FFFE);
        run_instr("sub_r7", OP_SUB, 5'd7, 5'd3, 5'd3, 64'd0);
        check_eq("sub_r7_zero", 64'(flag_zero), 64'd1);
        run_instr("li_r1", OP_LI, 5'd1, 5'd0, 5'd0, 64'h7FFF_FFFF_FFFF_FFFF);
        run_instr("li_r2", OP_LI, 5'd2, 5'd0, 5'd0, 64'd1);
        run_instr("add_ovf", OP_ADD, 5'd8, 5'd1, 5'd2, 64'd0);
        check_eq("add_ovf_const", {result[63:1], flag_ovf}, {63'h4000_0000_0000_0000, 1'b1});
        run_instr("st_wrap", OP_STORE, 5'd0, 5'd0, 5'd5, 64'd33);
        check_eq("st_wrap_dm1", dm_m[1], 64'hC);
        run_instr("ld_r9", OP_LOAD, 5'd9, 5'd0, 5'd0, 64'd1);
        check_eq("ld_r9_const", result, 64'hC);
        run_instr("illegal", 7'h7F, 5'd5, 5'd3, 5'd4, 64'd0);
        readback("rb_r5_after_ill", 5'd5);
        run_instr("none", OP_NONE, 5'd5, 5'd1, 5'd2, 64'd99);
        run_instr("wr_r0", OP_LI, 5'd0, 5'd0, 5'd0, 64'h55);
        check_eq("wr_r0_res", result, 64'h55);
        readback("rb_r0", 5'd0);

        // instr_valid held high through a busy instruction.
        wait_ready();
        op_code = OP_LI; rd = 5'd11; imm = 64'hAA; instr_valid = 1'b1;
        @(posedge clk); #1;
        op_code = OP_LI; rd = 5'd12; imm = 64'hBB;
        for (int k = 0; k < 3; k++) begin
            check_eq("held_rdy_low", 64'(instr_ready), 64'd0);
            @(posedge clk); #1;
        end
        check_eq("held_done1", 64'(done), 64'd1);
        check_eq("held_rdy_hi", 64'(instr_ready), 64'd1);
        check_eq("held_res1", result, 64'hAA);
        @(posedge clk); #1;
        instr_valid = 1'b0;
        scramble_fields();
        wait_done("held2", 3);
        check_eq("held_res2", result, 64'hBB);
        rf_m[11] = 64'hAA; rf_m[12] = 64'hBB; m_res = 64'hBB; m_zero = 1'b0; m_ovf = 1'b0;
        readback("rb_r11", 5'd11);

        // Reset during EXEC of ADD r10 must abort the write.
        run_instr("li_r10", OP_LI, 5'd10, 5'd0, 5'd0, 64'h1234);
        wait_ready();
        op_code = OP_ADD; rd = 5'd10; rs1 = 5'd3; rs2 = 5'd4; instr_valid = 1'b1;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1; #1;
        check_eq("abort_ready", 64'(instr_ready), 64'd1);
        check_eq("abort_done", 64'(done), 64'd0);
        check_eq("abort_res", result, 64'd0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        m_res = '0; m_zero = 1'b0; m_ovf = 1'b0;
        readback("rb_r10", 5'd10);
        check_eq("rb_r10_const", result, 64'h1234);

        for (int n = 0; n < 300; n++) begin
            logic [6:0] op;
            int sel;
            sel = $urandom_range(0, 19);
            if      (sel == 0)  op = OP_NONE;
            else if (sel <= 3)  op = OP_STORE;
            else if (sel <= 7)  op = OP_ADD;
            else if (sel <= 11) op = OP_SUB;
            else if (sel <= 15) op = OP_LOAD;
            else if (sel <= 18) op = OP_LI;
            else                op = 7'($urandom_range(6, 127));
            run_instr("rnd", op, 5'($urandom), 5'($urandom), 5'($urandom), {$urandom, $urandom});
        end
        for (int i = 0; i < 32; i++) readback("rb_final", 5'(i));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
